// File: rtl/dbg_run_controller.sv
// Run-control sequencer for the debug core: turns halt/step/resume strobes into a
// registered debug-clock enable, with multi-cycle stepping and a cycle-count breakpoint.
module dbg_run_controller #(
    parameter int STEP_W = 8,
    parameter int CYC_W  = 16
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              halt_stb,
    input  logic              step_stb,
    input  logic              resume_stb,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bkpt_en,
    input  logic [CYC_W-1:0]  bkpt_cycle,
    input  logic              cnt_clr,
    output logic              clk_en,
    output logic              halted,
    output logic [1:0]        state,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              step_done,
    output logic              bkpt_hit
);

    // Strobes carry no handshake: each is a single-cycle pulse, acted on in the
    // cycle it is high if valid for the current state, otherwise dropped silently.
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                clk_en_q, clk_en_d;
    logic                halted_q;
    logic                step_done_q, step_done_d;
    logic                bkpt_hit_q, bkpt_hit_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic [CYC_W-1:0]    cycle_count_q;
    logic                match;

    // Compare uses the pre-increment count, so the matching cycle is the last enabled one.
    assign match = bkpt_en & clk_en_q & (cycle_count_q == bkpt_cycle);

    always_comb begin
        state_d     = state_q;
        clk_en_d    = clk_en_q;
        bkpt_hit_d  = bkpt_hit_q;
        remaining_d = remaining_q;
        step_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt_stb) begin
                    state_d  = ST_HALT;
                    clk_en_d = 1'b0;
                end else if (match) begin
                    state_d    = ST_HALT;
                    clk_en_d   = 1'b0;
                    bkpt_hit_d = 1'b1;
                end
            end
            ST_HALT: begin
                if (step_stb) begin
                    state_d     = ST_STEP;
                    clk_en_d    = 1'b1;
                    bkpt_hit_d  = 1'b0;
                    remaining_d = (step_count == '0) ? STEP_W'(1) : step_count;
                end else if (resume_stb) begin
                    state_d    = ST_RUN;
                    clk_en_d   = 1'b1;
                    bkpt_hit_d = 1'b0;
                end
            end
            ST_STEP: begin
                if (halt_stb) begin
                    state_d  = ST_HALT;
                    clk_en_d = 1'b0;
                end else if (match) begin
                    state_d    = ST_HALT;
                    clk_en_d   = 1'b0;
                    bkpt_hit_d = 1'b1;
                end else if (clk_en_q && remaining_q == STEP_W'(1)) begin
                    state_d     = ST_HALT;
                    clk_en_d    = 1'b0;
                    step_done_d = 1'b1;
                end else if (clk_en_q) begin
                    remaining_d = remaining_q - STEP_W'(1);
                end
            end
            default: begin
                state_d  = ST_RUN;
                clk_en_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            clk_en_q    <= 1'b1;
            halted_q    <= 1'b0;
            step_done_q <= 1'b0;
            bkpt_hit_q  <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            clk_en_q    <= clk_en_d;
            halted_q    <= (state_d == ST_HALT);
            step_done_q <= step_done_d;
            bkpt_hit_q  <= bkpt_hit_d;
            remaining_q <= remaining_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset || cnt_clr) begin
            cycle_count_q <= '0;
        end else if (clk_en_q) begin
            cycle_count_q <= cycle_count_q + CYC_W'(1);
        end
    end

    assign clk_en      = clk_en_q;
    assign halted      = halted_q;
    assign state       = state_q;
    assign cycle_count = cycle_count_q;
    assign step_done   = step_done_q;
    assign bkpt_hit    = bkpt_hit_q;

endmodule

// File: tb/tb_dbg_run_controller.sv
// Directed bench for dbg_run_controller: a default-width instance for run/step/breakpoint
// behaviour and a 4-bit-counter instance for wrap and clear-vs-match ordering.
module tb_dbg_run_controller;

    logic        sys_clk;
    int          errors;
    int          checks;

    // 16-bit counter instance
    logic        reset, halt_stb, step_stb, resume_stb, bkpt_en, cnt_clr;
    logic [7:0]  step_count;
    logic [15:0] bkpt_cycle;
    logic        clk_en, halted, step_done, bkpt_hit;
    logic [1:0]  state;
    logic [15:0] cycle_count;

    // 4-bit counter instance
    logic        b_reset, b_halt_stb, b_step_stb, b_resume_stb, b_bkpt_en, b_cnt_clr;
    logic [7:0]  b_step_count;
    logic [3:0]  b_bkpt_cycle;
    logic        b_clk_en, b_halted, b_step_done, b_bkpt_hit;
    logic [1:0]  b_state;
    logic [3:0]  b_cycle_count;

    dbg_run_controller #(.STEP_W(8), .CYC_W(16)) dut (
        .sys_clk(sys_clk), .reset(reset), .halt_stb(halt_stb), .step_stb(step_stb),
        .resume_stb(resume_stb), .step_count(step_count), .bkpt_en(bkpt_en),
        .bkpt_cycle(bkpt_cycle), .cnt_clr(cnt_clr), .clk_en(clk_en), .halted(halted),
        .state(state), .cycle_count(cycle_count), .step_done(step_done), .bkpt_hit(bkpt_hit)
    );

    dbg_run_controller #(.STEP_W(8), .CYC_W(4)) dut_b (
        .sys_clk(sys_clk), .reset(b_reset), .halt_stb(b_halt_stb), .step_stb(b_step_stb),
        .resume_stb(b_resume_stb), .step_count(b_step_count), .bkpt_en(b_bkpt_en),
        .bkpt_cycle(b_bkpt_cycle), .cnt_clr(b_cnt_clr), .clk_en(b_clk_en), .halted(b_halted),
        .state(b_state), .cycle_count(b_cycle_count), .step_done(b_step_done), .bkpt_hit(b_bkpt_hit)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit after.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", state); end
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL reset_clk_en got=%b exp=1", clk_en); end
        checks++; if (halted !== 1'b0 || step_done !== 1'b0 || bkpt_hit !== 1'b0) begin
            errors++; $display("FAIL reset_flags got halted=%b step_done=%b bkpt_hit=%b exp=000", halted, step_done, bkpt_hit); end
        checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
        cyc(5);
        checks++; if (cycle_count !== 16'd5 || state !== 2'b00 || clk_en !== 1'b1) begin
            errors++; $display("FAIL idle_run got count=%0d state=%b clk_en=%b exp 5/00/1", cycle_count, state, clk_en); end
    endtask

    task automatic test_halt;
        halt_stb = 1'b1;
        cyc(1);
        halt_stb = 1'b0;
        checks++; if (clk_en !== 1'b0 || halted !== 1'b1 || state !== 2'b01) begin
            errors++; $display("FAIL halt_entry got clk_en=%b halted=%b state=%b exp 0/1/01", clk_en, halted, state); end
        checks++; if (cycle_count !== 16'd6) begin errors++; $display("FAIL halt_count got=%0d exp=6", cycle_count); end
        cyc(4);
        checks++; if (cycle_count !== 16'd6 || state !== 2'b01) begin
            errors++; $display("FAIL halt_frozen got count=%0d state=%b exp 6/01", cycle_count, state); end
    endtask

    // Runs one step from HALT and checks enabled-cycle count, done pulses and final count.
    task automatic run_step(input logic [7:0] n, input int exp_en, input logic [15:0] exp_count);
        int en_cycles;
        int done_pulses;
        int done_bad;
        en_cycles = 0; done_pulses = 0; done_bad = 0;
        step_count = n;
        step_stb = 1'b1;
        cyc(1);
        step_stb = 1'b0;
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL step_entry n=%0d got state=%b exp=10", n, state); end
        if (clk_en === 1'b1) en_cycles++;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (clk_en === 1'b1) en_cycles++;
            if (step_done === 1'b1) begin
                done_pulses++;
                if (halted !== 1'b1) done_bad++;
            end
        end
        checks++; if (en_cycles !== exp_en) begin errors++; $display("FAIL step_len n=%0d got=%0d exp=%0d", n, en_cycles, exp_en); end
        checks++; if (done_pulses !== 1 || done_bad !== 0) begin
            errors++; $display("FAIL step_done n=%0d got pulses=%0d unaligned=%0d exp 1/0", n, done_pulses, done_bad); end
        checks++; if (cycle_count !== exp_count || state !== 2'b01) begin
            errors++; $display("FAIL step_end n=%0d got count=%0d state=%b exp %0d/01", n, cycle_count, state, exp_count); end
    endtask

    task automatic test_step;
        run_step(8'd3, 3, 16'd9);
        run_step(8'd0, 1, 16'd10);
    endtask

    task automatic test_step_abort;
        int done_seen;
        done_seen = 0;
        step_count = 8'd20;
        step_stb = 1'b1;
        cyc(1);
        step_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (step_done === 1'b1) done_seen++;
        end
        halt_stb = 1'b1;
        cyc(1);
        halt_stb = 1'b0;
        if (step_done === 1'b1) done_seen++;
        checks++; if (state !== 2'b01 || clk_en !== 1'b0) begin
            errors++; $display("FAIL abort_state got state=%b clk_en=%b exp 01/0", state, clk_en); end
        checks++; if (cycle_count !== 16'd15) begin errors++; $display("FAIL abort_count got=%0d exp=15", cycle_count); end
        cyc(3);
        if (step_done === 1'b1) done_seen++;
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
    endtask

    task automatic test_strobe_priority;
        step_count = 8'd2;
        halt_stb = 1'b1; step_stb = 1'b1; resume_stb = 1'b1;
        cyc(1);
        halt_stb = 1'b0; step_stb = 1'b0; resume_stb = 1'b0;
        checks++; if (state !== 2'b10 || clk_en !== 1'b1) begin
            errors++; $display("FAIL triple_in_halt got state=%b clk_en=%b exp 10/1", state, clk_en); end
        cyc(2);
        checks++; if (state !== 2'b01 || step_done !== 1'b1 || cycle_count !== 16'd17) begin
            errors++; $display("FAIL triple_step_end got state=%b done=%b count=%0d exp 01/1/17", state, step_done, cycle_count); end
        resume_stb = 1'b1;
        cyc(1);
        resume_stb = 1'b0;
        checks++; if (state !== 2'b00 || clk_en !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL resume got state=%b clk_en=%b halted=%b exp 00/1/0", state, clk_en, halted); end
        halt_stb = 1'b1; step_stb = 1'b1; resume_stb = 1'b1;
        cyc(1);
        halt_stb = 1'b0; step_stb = 1'b0; resume_stb = 1'b0;
        checks++; if (state !== 2'b01 || cycle_count !== 16'd18) begin
            errors++; $display("FAIL triple_in_run got state=%b count=%0d exp 01/18", state, cycle_count); end
    endtask

    task automatic test_bkpt;
        int waited;
        waited = 0;
        bkpt_en = 1'b1;
        bkpt_cycle = 16'd10;
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        while (halted !== 1'b1 && waited < 40) begin
            cyc(1);
            waited++;
        end
        checks++; if (waited !== 11) begin errors++; $display("FAIL bkpt_latency got=%0d exp=11", waited); end
        checks++; if (cycle_count !== 16'd11 || bkpt_hit !== 1'b1 || state !== 2'b01) begin
            errors++; $display("FAIL bkpt_halt got count=%0d hit=%b state=%b exp 11/1/01", cycle_count, bkpt_hit, state); end
        cyc(3);
        checks++; if (cycle_count !== 16'd11 || bkpt_hit !== 1'b1) begin
            errors++; $display("FAIL bkpt_sticky got count=%0d hit=%b exp 11/1", cycle_count, bkpt_hit); end
        resume_stb = 1'b1;
        cyc(1);
        resume_stb = 1'b0;
        checks++; if (state !== 2'b00 || bkpt_hit !== 1'b0) begin
            errors++; $display("FAIL bkpt_resume got state=%b hit=%b exp 00/0", state, bkpt_hit); end
        bkpt_en = 1'b0;
    endtask

    task automatic test_reset_mid_step;
        halt_stb = 1'b1;
        cyc(1);
        halt_stb = 1'b0;
        step_count = 8'd20;
        step_stb = 1'b1;
        cyc(1);
        step_stb = 1'b0;
        cyc(3);
        reset = 1'b1; halt_stb = 1'b1; cnt_clr = 1'b0;
        cyc(1);
        reset = 1'b0; halt_stb = 1'b0;
        checks++; if (state !== 2'b00 || clk_en !== 1'b1 || halted !== 1'b0 || cycle_count !== 16'd0) begin
            errors++; $display("FAIL reset_mid_step got state=%b clk_en=%b halted=%b count=%0d exp 00/1/0/0",
                               state, clk_en, halted, cycle_count); end
    endtask

    task automatic test_wrap_and_clear;
        int waited;
        waited = 0;
        b_reset = 1'b1;
        cyc(1);
        b_reset = 1'b0;
        cyc(15);
        checks++; if (b_cycle_count !== 4'd15) begin errors++; $display("FAIL wrap_pre got=%0d exp=15", b_cycle_count); end
        b_bkpt_en = 1'b1; b_cnt_clr = 1'b1;
        cyc(1);
        b_cnt_clr = 1'b0;
        checks++; if (b_cycle_count !== 4'd0 || b_state !== 2'b00 || b_bkpt_hit !== 1'b0) begin
            errors++; $display("FAIL clr_no_match got count=%0d state=%b hit=%b exp 0/00/0", b_cycle_count, b_state, b_bkpt_hit); end
        cyc(1);
        checks++; if (b_cycle_count !== 4'd1 || b_state !== 2'b01 || b_bkpt_hit !== 1'b1) begin
            errors++; $display("FAIL clr_then_match got count=%0d state=%b hit=%b exp 1/01/1", b_cycle_count, b_state, b_bkpt_hit); end
        b_resume_stb = 1'b1;
        cyc(1);
        b_resume_stb = 1'b0;
        while (b_halted !== 1'b1 && waited < 40) begin
            cyc(1);
            waited++;
        end
        checks++; if (waited !== 16 || b_cycle_count !== 4'd1 || b_bkpt_hit !== 1'b1) begin
            errors++; $display("FAIL wrap_match got waited=%0d count=%0d hit=%b exp 16/1/1", waited, b_cycle_count, b_bkpt_hit); end
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; halt_stb = 1'b0; step_stb = 1'b0; resume_stb = 1'b0;
        bkpt_en = 1'b0; cnt_clr = 1'b0; step_count = 8'd0; bkpt_cycle = 16'd0;
        b_reset = 1'b1; b_halt_stb = 1'b0; b_step_stb = 1'b0; b_resume_stb = 1'b0;
        b_bkpt_en = 1'b0; b_cnt_clr = 1'b0; b_step_count = 8'd0; b_bkpt_cycle = 4'd0;
        cyc(2);
        test_reset;
        test_halt;
        test_step;
        test_step_abort;
        test_strobe_priority;
        test_bkpt;
        test_reset_mid_step;
        test_wrap_and_clear;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbg_run_controller.md
# dbg_run_controller

Run-control sequencer for the debug core in the `sys_clk` domain. It takes the single-cycle halt/step/resume strobes produced by the JTAG-to-`sys_clk` synchronisers and drives the registered clock-enable that gates the debug clock. It adds multi-cycle stepping, a cycle-count breakpoint and status reporting. It replaces the fixed three-state run/halt/single-step loop, and sits between the strobe synchronisers and the negedge clock-gate latch.

## Interface
Parameters:
- `STEP_W`, 8: width of the step-length input.
- `CYC_W`, 16: width of the enabled-cycle counter and the breakpoint compare value.

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `halt_stb`  in  1  one-cycle halt request.
- `step_stb`  in  1  one-cycle step request.
- `resume_stb`  in  1  one-cycle resume request.
- `step_count`  in  STEP_W  step length in enabled cycles; sampled when a step is accepted; 0 is treated as 1.
- `bkpt_en`  in  1  enables the cycle breakpoint.
- `bkpt_cycle`  in  CYC_W  breakpoint compare value.
- `cnt_clr`  in  1  synchronous clear of `cycle_count`.
- `clk_en`  out  1  registered gate enable; the downstream negedge latch consumes it.
- `halted`  out  1  high in HALT.
- `state`  out  2  RUN=00, HALT=01, STEP=10; 11 is never produced.
- `cycle_count`  out  CYC_W  number of cycles with `clk_en`=1; wraps modulo 2^CYC_W.
- `step_done`  out  1  one-cycle pulse when a step completes normally.
- `bkpt_hit`  out  1  sticky flag: the breakpoint caused the last halt.

## Operation
- Reset values: `state`=RUN, `clk_en`=1, `halted`=0, `cycle_count`=0, `step_done`=0, `bkpt_hit`=0, internal `remaining`=0.
- Enabled cycle: any cycle in which the registered `clk_en` is 1. `cycle_count` and `remaining` update only on enabled cycles.
- `match` = `bkpt_en` & `clk_en` & (`cycle_count` == `bkpt_cycle`).
- Strobe priority within a cycle: halt > step > resume. Strobes that are invalid in the current state are ignored, with no side effects.

RUN:
- `halt_stb` -> HALT, `clk_en`←0.
- Else `match` -> HALT, `clk_en`←0, `bkpt_hit`←1.
- `step_stb` and `resume_stb` are ignored.

HALT:
- `step_stb` -> STEP, `clk_en`←1, `remaining`←max(`step_count`,1), `bkpt_hit`←0.
- Else `resume_stb` -> RUN, `clk_en`←1, `bkpt_hit`←0.
- `halt_stb` is ignored.

STEP:
- `halt_stb` -> HALT, `clk_en`←0. This is an abort: no `step_done`.
- Else `match` -> HALT, `clk_en`←0, `bkpt_hit`←1, no `step_done`.
- Else, on an enabled cycle with `remaining`==1 -> HALT, `clk_en`←0, `step_done`←1.
- Otherwise `remaining` decrements.
- `step_stb` and `resume_stb` are ignored.

Counter:
- `cnt_clr` has priority over increment; `cycle_count`←0 on that edge.
- `match` uses the pre-increment value.
- `step_done` defaults to 0 every cycle.
- `halted` = (`state`==HALT), registered alongside `state`.

## Timing
- All outputs are registered. A strobe sampled at edge E changes the outputs immediately after E: one-cycle latency.
- Halt: `clk_en` is 0 from the cycle after the strobe. The strobe cycle itself is still an enabled cycle and counts.
- Step of N: `clk_en` is high for exactly N consecutive cycles. `step_done` pulses in the cycle after the last enabled cycle, coincident with `halted` rising.
- Breakpoint: the cycle with `cycle_count`==`bkpt_cycle` is the last enabled cycle. After the halt, `cycle_count`=`bkpt_cycle`+1 (mod 2^CYC_W).
- Wrap: `cycle_count` at all-ones increments to 0. A breakpoint at value 0 matches after the wrap.
- `reset` mid-STEP or in HALT returns to RUN with `clk_en`=1 on the next edge. `reset` overrides all strobes and `cnt_clr`.
- `cnt_clr` coincident with `match`: the match is evaluated on the old value, then the counter clears to 0.

## Test plan
- Reset, then 5 idle cycles -> `state`=00, `clk_en`=1, `cycle_count`=5; then `halt_stb` -> `clk_en`=0 next cycle, `halted`=1, `cycle_count`=6 and frozen.
- From HALT, `step_count`=3 with `step_stb` -> `clk_en` high for exactly 3 cycles, `cycle_count` +3, one `step_done` pulse, `state`=01. Repeat with `step_count`=0 -> exactly 1 enabled cycle.
- `bkpt_en`=1, `bkpt_cycle`=10, run from reset -> halt with `cycle_count`=11, `bkpt_hit`=1. Then `resume_stb` -> RUN and `bkpt_hit`=0.
- Step of 20 with `halt_stb` after 4 enabled cycles -> HALT, `cycle_count` +5 (strobe cycle counts), no `step_done`.
- `halt_stb`, `step_stb` and `resume_stb` all high in HALT -> STEP entered (halt ignored in HALT). The same triple in RUN -> HALT.
- CYC_W=4, `bkpt_cycle`=0, `cnt_clr` at count 15 -> counter 0 and no match that cycle; the next cycle matches, halting with `cycle_count`=1. `reset` asserted mid-STEP -> RUN and `clk_en`=1 next cycle.
